// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Iterative restoring divider. Divides an unsigned DW-bit dividend by an
//   unsigned VW-bit divisor, producing one quotient bit per clock. Results are
//   a DW-bit quotient and a VW-bit remainder. A zero divisor finishes
//   immediately with an all-ones quotient, a zero remainder and div_by_zero set.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request, sampled only while not busy (IDLE / DONE)
//   dividend     in   DW  dividend, captured on the accepting edge
//   divisor      in   VW  divisor, captured on the accepting edge
//   busy         out  1   high while a division is iterating
//   done         out  1   one-cycle pulse when results become valid
//   quotient     out  DW  result quotient, held until the next accepted start
//   remainder    out  VW  result remainder, held until the next accepted start
//   div_by_zero  out  1   flags a zero divisor, held like the results
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [CW-1:0] count_q,     count_d;
    logic [VW:0]   rem_q,       rem_d;
    // Dividend shift register; quotient bits fill in from the LSB as the
    // dividend bits leave from the MSB, so after DW steps it holds the quotient.
    logic [DW-1:0] dvd_q,       dvd_d;
    logic [VW-1:0] dvs_q,       dvs_d;
    logic [DW-1:0] quotient_q,  quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q,       dbz_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    logic [VW:0]   trial_s;
    logic [VW:0]   diff_s;
    logic          ge_s;

    // Next-state, datapath step and output-register decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        trial_s = {rem_q[VW-1:0], dvd_q[DW-1]};
        diff_s  = trial_s - {1'b0, dvs_q};
        // The top remainder bit is always zero for a well-formed remainder;
        // folding it in keeps a corrupted remainder from looking smaller.
        ge_s    = (trial_s >= {1'b0, dvs_q}) | rem_q[VW];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d       = dividend;
                    dvs_d       = divisor;
                    rem_d       = '0;
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    if (divisor == '0) begin
                        state_d    = S_DONE;
                        count_d    = '0;
                        quotient_d = '1;
                        dbz_d      = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        count_d = CW'(DW);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (ge_s) begin
                    rem_d = diff_s;
                end else begin
                    rem_d = trial_s;
                end
                dvd_d   = {dvd_q[DW-2:0], ge_s};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d     = S_DONE;
                    quotient_d  = dvd_d;
                    remainder_d = rem_d[VW-1:0];
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Self-checking bench for seq_restoring_divider (DW=8, VW=4). Expected
//   results come from plain integer division in the bench.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.DW(8), .VW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer division, zero divisor saturates.
    function automatic logic [7:0] ref_q(input int a, input int b);
        if (b == 0) return 8'hFF;
        return 8'(a / b);
    endfunction

    function automatic logic [3:0] ref_r(input int a, input int b);
        if (b == 0) return 4'd0;
        return 4'(a % b);
    endfunction

    // Issue one operation and wait (bounded) for done. Returns at the negedge
    // where done is seen. lat counts cycles from the accepting edge to done
    // (1 = the cycle right after the accepting edge); lat=0 means timeout.
    task automatic run_op(input int a, input int b, input bit in_place,
                          output logic [7:0] q, output logic [3:0] r,
                          output logic z, output int busy_n, output int lat);
        if (!in_place) @(negedge clk);
        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        busy_n = 0;
        lat    = 0;
        q      = 8'hxx;
        r      = 4'hx;
        z      = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                q   = quotient;
                r   = remainder;
                z   = div_by_zero;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        #3;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got %h, want 0",
                     {busy, done, quotient, remainder, div_by_zero});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h, want 0",
                     {busy, done, quotient, remainder, div_by_zero});
        end
    endtask

    task automatic test_basic();
        logic [7:0] q; logic [3:0] r; logic z; int bn, lat;
        run_op(200, 7, 1'b0, q, r, z, bn, lat);
        checks++;
        if ({q, r, z} !== {8'd28, 4'd4, 1'b0}) begin
            errors++;
            $display("FAIL basic_200_7: got q=%0d r=%0d z=%0d, want q=28 r=4 z=0", q, r, z);
        end
        checks++;
        if (bn !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bn);
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 9", lat);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 8'd28, 4'd4}) begin
            errors++;
            $display("FAIL basic_hold: got done=%0d busy=%0d q=%0d r=%0d, want 0 0 28 4",
                     done, busy, quotient, remainder);
        end
    endtask

    task automatic test_edges();
        int ta[5] = '{255, 255, 0, 9, 225};
        int tb[5] = '{1, 15, 5, 10, 15};
        logic [7:0] q; logic [3:0] r; logic z; int bn, lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 1'b0, q, r, z, bn, lat);
            checks++;
            if ({q, r, z} !== {ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]), 1'b0}) begin
                errors++;
                $display("FAIL edge_%0d_%0d: got q=%0d r=%0d z=%0d, want q=%0d r=%0d z=0",
                         ta[i], tb[i], q, r, z, ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q; logic [3:0] r; logic z; int bn, lat;
        run_op(77, 0, 1'b0, q, r, z, bn, lat);
        checks++;
        if ({q, r, z} !== {8'd255, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL div0_result: got q=%0d r=%0d z=%0d, want q=255 r=0 z=1", q, r, z);
        end
        checks++;
        if (lat !== 1 || bn !== 0) begin
            errors++;
            $display("FAIL div0_timing: got lat=%0d busy=%0d, want lat=1 busy=0", lat, bn);
        end
        @(negedge clk);
        checks++;
        if ({done, div_by_zero} !== 2'b01) begin
            errors++;
            $display("FAIL div0_pulse_hold: got done=%0d z=%0d, want done=0 z=1", done, div_by_zero);
        end
        run_op(100, 3, 1'b0, q, r, z, bn, lat);
        checks++;
        if ({q, r, z} !== {8'd33, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL div0_clear: got q=%0d r=%0d z=%0d, want q=33 r=1 z=0", q, r, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q; logic [3:0] r; logic z; int bn, lat;
        bit seen;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen || {quotient, remainder} !== {8'd33, 4'd1}) begin
            errors++;
            $display("FAIL ignore_start_in_run: got seen=%0d q=%0d r=%0d, want seen=1 q=33 r=1",
                     seen, quotient, remainder);
        end
        run_op(50, 5, 1'b1, q, r, z, bn, lat);
        checks++;
        if ({q, r, z} !== {8'd10, 4'd0, 1'b0} || lat !== 9) begin
            errors++;
            $display("FAIL back_to_back: got q=%0d r=%0d z=%0d lat=%0d, want q=10 r=0 z=0 lat=9",
                     q, r, z, lat);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] q; logic [3:0] r; logic z; int bn, lat;
        int dones;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset_midrun: got %h, want 0",
                     {busy, done, quotient, remainder, div_by_zero});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL no_done_after_abort: got %0d active cycles, want 0", dones);
        end
        run_op(200, 7, 1'b0, q, r, z, bn, lat);
        checks++;
        if ({q, r, z} !== {8'd28, 4'd4, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_op: got q=%0d r=%0d z=%0d, want q=28 r=4 z=0", q, r, z);
        end
    endtask

    task automatic test_random();
        logic [7:0] q; logic [3:0] r; logic z; int bn, lat;
        int a, b;
        bit chain;
        for (int n = 0; n < 150; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            chain = (n != 0) && ($urandom_range(0, 1) == 1);
            run_op(a, b, chain, q, r, z, bn, lat);
            checks++;
            if ({q, r, z} !== {ref_q(a, b), ref_r(a, b), (b == 0)} ||
                lat !== ((b == 0) ? 1 : 9)) begin
                errors++;
                $display("FAIL random_%0d_%0d: got q=%0d r=%0d z=%0d lat=%0d, want q=%0d r=%0d z=%0d",
                         a, b, q, r, z, lat, ref_q(a, b), ref_r(a, b), (b == 0));
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] q; logic [3:0] r; logic z; int bn, lat;
        bit bad;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a, b, 1'b1, q, r, z, bn, lat);
                if (b == 0) begin
                    bad = ({q, r, z} !== {8'hFF, 4'd0, 1'b1});
                end else begin
                    bad = (lat == 0) || (z !== 1'b0) ||
                          (int'(q) * b + int'(r) != a) || (int'(r) >= b) ||
                          (q !== ref_q(a, b));
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d z=%0d, want q=%0d r=%0d z=%0d",
                             a, b, q, r, z, ref_q(a, b), ref_r(a, b), (b == 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        test_sweep();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
